controle_partida: RTL and testbench
===================================

// Module: controle_partida
// PURPOSE
//  Game controller sequencing the two-team basketball scoreboard datapath. Turns raw point buttons into
//  single-cycle point codes and routes each to exactly one team datapath (the per-team accumulators).
//  Runs the period clock and counts periods. Clears the scoreboards at game start.
//  Sits between the board buttons/switches and the per-team score accumulators + display logic.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clock cycles per game second (prescaler terminal count)
//  PERIOD_SEC     600         seconds per period; must be <= 1023
//  NUM_PERIODS    4           periods per game; 1..7
// PORTS
//  clock       in   1   system clock, rising edge
//  clr         in   1   asynchronous reset, active-low
//  btn_start   in   1   start/pause button, level, already debounced
//  btn_pts     in   2   point buttons, already debounced: 00 none, 01=1pt, 10=2pt, 11=3pt
//  chave_time  in   1   team select: 0 = team 1, 1 = team 2
//  soma_t1     out  2   point code to team-1 accumulator; 00 except one-cycle pulse
//  soma_t2     out  2   point code to team-2 accumulator; 00 except one-cycle pulse
//  clr_placar  out  1   active-low scoreboard clear, one-cycle pulse
//  periodo     out  3   current period, 1..NUM_PERIODS
//  seg_rest    out  10  seconds remaining in period
//  estado      out  3   FSM state code (package encoding)
//  fim_jogo    out  1   high while in FIM
// BEHAVIOUR
//  Reset (clr=0, immediate): estado=PARADO, periodo=1, seg_rest=PERIOD_SEC, prescaler=0, soma_t1=soma_t2=00,
//   clr_placar=1, fim_jogo=0, edge registers=0.
//  All outputs are registered. Start event = btn_start 0->1 between consecutive edges (one event per press).
//  Point event = registered btn_pts==00 and input btn_pts!=00. Event code = the input value.
//   A nonzero->nonzero change (e.g. 01->11) is not an event.
//  Point pulse: on the edge that detects the event, soma_tX <= code for exactly one cycle. Latency 1 clock.
//   chave_time is sampled on that same edge; the other team output stays 00.
//   Events are honoured only in RODANDO and PAUSADO and dropped in every other state.
//  FSM (each transition on a start event unless noted):
//   PARADO -> RODANDO: clr_placar=0 for one cycle. periodo=1, seg_rest=PERIOD_SEC, prescaler=0.
//   RODANDO -> PAUSADO; PAUSADO -> RODANDO: prescaler holds its value while paused (not cleared).
//   RODANDO, seconds expire (no event): seg_rest reaches 0 ->
//     INTERVALO if periodo<NUM_PERIODS, else FIM (fim_jogo=1).
//   INTERVALO -> RODANDO: periodo+1, seg_rest=PERIOD_SEC, prescaler=0.
//   FIM -> PARADO: fim_jogo=0, periodo=1, seg_rest=PERIOD_SEC. Scores are kept until the next game start.
//  Timer: only in RODANDO. prescaler counts 0..TICKS_PER_SEC-1. At the terminal count it wraps to 0 and
//   seg_rest decrements. seg_rest never wraps below 0.
//  Simultaneous events:
//   - Expiry and start event in the same cycle: expiry wins, the start event is discarded.
//   - Point event in the expiry cycle: accepted (state was RODANDO).
//   - Start event and point event in the same cycle: both take effect.
//  clr mid-operation: reset values immediately. The in-flight point pulse is lost; clr_placar is not pulsed.
// STRUCTURE
//  Package controle_pkg holds:
//   - state encodings PARADO=0, RODANDO=1, PAUSADO=2, INTERVALO=3, FIM=4;
//   - point codes PTS_NONE/PTS_1/PTS_2/PTS_3;
//   - width constants SEG_W=10, PER_W=3.
//  Sub-module temporizador_periodo:
//   - contains the prescaler ($clog2(TICKS_PER_SEC) bits) and the seconds down-counter;
//   - inputs load/en; outputs seg_rest and expira (one-cycle pulse when the count reaches 0).
//  FSM, edge detection and point routing live in the top.
// TESTING (bench params TICKS_PER_SEC=4, PERIOD_SEC=3, NUM_PERIODS=2)
//  1 Reset, then start press -> estado=RODANDO after 1 edge; clr_placar=0 for exactly 1 cycle; seg_rest=3, periodo=1.
//  2 RODANDO, chave_time=1, btn_pts 00->10 held 5 cycles, then ->11 -> soma_t2=10 for 1 cycle only;
//    soma_t1=00 throughout; no pulse on the 11 change.
//  3 btn_pts=01 pulsed in PARADO, INTERVALO, FIM -> soma_t1=soma_t2=00 throughout.
//  4 Run 12 cycles -> seg_rest 3,2,1,0, then INTERVALO, periodo=1. Start -> RODANDO, periodo=2, seg_rest=3.
//    12 more cycles -> FIM, fim_jogo=1. Start -> PARADO, fim_jogo=0.
//  5 Pause after 2 prescaler counts for 10 cycles, resume -> seg_rest decrements 2 cycles after resume, not 4.
//  6 Start press and expiry in the same cycle -> INTERVALO (start ignored).
//    clr=0 mid-RODANDO -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/controle_pkg.sv
// Shared encodings and widths for the basketball game controller.
package controle_pkg;

    localparam int unsigned SEG_W = 10;
    localparam int unsigned PER_W = 3;

    typedef enum logic [2:0] {
        PARADO    = 3'd0,
        RODANDO   = 3'd1,
        PAUSADO   = 3'd2,
        INTERVALO = 3'd3,
        FIM       = 3'd4
    } estado_t;

    typedef enum logic [1:0] {
        PTS_NONE = 2'b00,
        PTS_1    = 2'b01,
        PTS_2    = 2'b10,
        PTS_3    = 2'b11
    } pts_t;

endpackage

// File: rtl/controle_partida_temporizador.sv
// Period timer: per-second prescaler feeding a saturating seconds down-counter.
module temporizador_periodo
    import controle_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned PERIOD_SEC    = 600
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    output logic [SEG_W-1:0] seg_rest,
    output logic             expira
);

    localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    logic [PRE_W-1:0] prescaler;
    logic             tick;

    assign tick   = en && (prescaler == PRE_W'(TICKS_PER_SEC - 1));
    // Expiry is the edge on which the count steps from 1 to 0.
    assign expira = tick && (seg_rest == SEG_W'(1));

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            prescaler <= '0;
            seg_rest  <= SEG_W'(PERIOD_SEC);
        end else if (load) begin
            prescaler <= '0;
            seg_rest  <= SEG_W'(PERIOD_SEC);
        end else if (en) begin
            if (tick) begin
                prescaler <= '0;
                if (seg_rest != '0) begin
                    seg_rest <= seg_rest - SEG_W'(1);
                end
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/controle_partida.sv
// Game controller: start/pause FSM, period sequencing and per-team point routing.
module controle_partida
    import controle_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned PERIOD_SEC    = 600,
    parameter int unsigned NUM_PERIODS   = 4
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             btn_start,
    input  logic [1:0]       btn_pts,
    input  logic             chave_time,
    output logic [1:0]       soma_t1,
    output logic [1:0]       soma_t2,
    output logic             clr_placar,
    output logic [PER_W-1:0] periodo,
    output logic [SEG_W-1:0] seg_rest,
    output logic [2:0]       estado,
    output logic             fim_jogo
);

    estado_t          state;
    estado_t          stateNext;
    logic             startQ;
    logic [1:0]       ptsQ;
    logic             startEv;
    logic             ptsEv;
    logic             loadTimer;
    logic             clrPulse;
    logic             expira;
    logic [PER_W-1:0] periodoNext;
    logic [1:0]       soma1Next;
    logic [1:0]       soma2Next;

    assign startEv = btn_start && !startQ;
    assign ptsEv   = (ptsQ == PTS_NONE) && (btn_pts != PTS_NONE);
    assign estado  = state;

    temporizador_periodo #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .PERIOD_SEC   (PERIOD_SEC)
    ) u_temporizador (
        .clock   (clock),
        .clr     (clr),
        .load    (loadTimer),
        .en      (state == RODANDO),
        .seg_rest(seg_rest),
        .expira  (expira)
    );

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state <= PARADO;
        end else begin
            state <= stateNext;
        end
    end

    // Next state; expiry outranks a start press in the same cycle.
    always_comb begin
        stateNext   = state;
        loadTimer   = 1'b0;
        clrPulse    = 1'b0;
        periodoNext = periodo;
        soma1Next   = PTS_NONE;
        soma2Next   = PTS_NONE;
        unique case (state)
            PARADO: begin
                if (startEv) begin
                    stateNext   = RODANDO;
                    loadTimer   = 1'b1;
                    clrPulse    = 1'b1;
                    periodoNext = PER_W'(1);
                end
            end
            RODANDO: begin
                if (expira) begin
                    stateNext = (periodo < PER_W'(NUM_PERIODS)) ? INTERVALO : FIM;
                end else if (startEv) begin
                    stateNext = PAUSADO;
                end
            end
            PAUSADO: begin
                if (startEv) begin
                    stateNext = RODANDO;
                end
            end
            INTERVALO: begin
                if (startEv) begin
                    stateNext   = RODANDO;
                    loadTimer   = 1'b1;
                    periodoNext = periodo + PER_W'(1);
                end
            end
            FIM: begin
                if (startEv) begin
                    stateNext   = PARADO;
                    loadTimer   = 1'b1;
                    periodoNext = PER_W'(1);
                end
            end
            default: begin
                stateNext = PARADO;
            end
        endcase
        if (ptsEv && (state == RODANDO || state == PAUSADO)) begin
            if (chave_time) begin
                soma2Next = btn_pts;
            end else begin
                soma1Next = btn_pts;
            end
        end
    end

    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            periodo    <= PER_W'(1);
            soma_t1    <= PTS_NONE;
            soma_t2    <= PTS_NONE;
            clr_placar <= 1'b1;
            fim_jogo   <= 1'b0;
            startQ     <= 1'b0;
            ptsQ       <= PTS_NONE;
        end else begin
            periodo    <= periodoNext;
            soma_t1    <= soma1Next;
            soma_t2    <= soma2Next;
            clr_placar <= !clrPulse;
            fim_jogo   <= (stateNext == FIM);
            startQ     <= btn_start;
            ptsQ       <= btn_pts;
        end
    end

endmodule

// File: tb/tb_controle_partida.sv
// Vector-table bench for controle_partida with a small expected-result queue.
module tb_controle_partida;
    import controle_pkg::*;

    logic             clock;
    logic             clr;
    logic             btn_start;
    logic [1:0]       btn_pts;
    logic             chave_time;
    logic [1:0]       soma_t1;
    logic [1:0]       soma_t2;
    logic             clr_placar;
    logic [PER_W-1:0] periodo;
    logic [SEG_W-1:0] seg_rest;
    logic [2:0]       estado;
    logic             fim_jogo;

    typedef struct {
        logic       st;
        logic [1:0] pts;
        logic       ch;
        estado_t    est;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       clrp;
        int         per;
        int         seg;
        logic       fim;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    controle_partida #(
        .TICKS_PER_SEC(4),
        .PERIOD_SEC   (3),
        .NUM_PERIODS  (2)
    ) dut (
        .clock     (clock),
        .clr       (clr),
        .btn_start (btn_start),
        .btn_pts   (btn_pts),
        .chave_time(chave_time),
        .soma_t1   (soma_t1),
        .soma_t2   (soma_t2),
        .clr_placar(clr_placar),
        .periodo   (periodo),
        .seg_rest  (seg_rest),
        .estado    (estado),
        .fim_jogo  (fim_jogo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic st, input logic [1:0] pts, input logic ch,
                                input estado_t est, input logic [1:0] s1, input logic [1:0] s2,
                                input logic clrp, input int per, input int seg, input logic fim);
        vec_t v;
        v.st = st; v.pts = pts; v.ch = ch; v.est = est; v.s1 = s1; v.s2 = s2;
        v.clrp = clrp; v.per = per; v.seg = seg; v.fim = fim;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s row %0d: got %0d want %0d", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input vec_t e);
        chk("estado", row, int'(estado), int'(e.est));
        chk("soma_t1", row, int'(soma_t1), int'(e.s1));
        chk("soma_t2", row, int'(soma_t2), int'(e.s2));
        chk("clr_placar", row, int'(clr_placar), int'(e.clrp));
        chk("periodo", row, int'(periodo), e.per);
        chk("seg_rest", row, int'(seg_rest), e.seg);
        chk("fim_jogo", row, int'(fim_jogo), int'(e.fim));
    endtask

    initial begin
        vec_t e;
        vec_t rst_v;

        // Point press while stopped, then game start.
        vecs.push_back(mk(0, 2'd1, 0, PARADO,    0, 0, 1, 1, 3, 0));
        vecs.push_back(mk(0, 2'd0, 0, PARADO,    0, 0, 1, 1, 3, 0));
        vecs.push_back(mk(1, 2'd0, 0, RODANDO,   0, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 1, 3, 0));
        // Team 2 scores 2 pts held, then 10->11 must not pulse.
        vecs.push_back(mk(0, 2'd2, 1, RODANDO,   0, 2, 1, 1, 3, 0));
        vecs.push_back(mk(0, 2'd2, 1, RODANDO,   0, 0, 1, 1, 3, 0));
        vecs.push_back(mk(0, 2'd2, 1, RODANDO,   0, 0, 1, 1, 2, 0));
        vecs.push_back(mk(0, 2'd2, 1, RODANDO,   0, 0, 1, 1, 2, 0));
        vecs.push_back(mk(0, 2'd2, 1, RODANDO,   0, 0, 1, 1, 2, 0));
        vecs.push_back(mk(0, 2'd3, 1, RODANDO,   0, 0, 1, 1, 2, 0));
        vecs.push_back(mk(0, 2'd0, 1, RODANDO,   0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 1, 1, 0));
        // Expiry + start + point in the same cycle.
        vecs.push_back(mk(1, 2'd1, 0, INTERVALO, 1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'd1, 0, INTERVALO, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'd0, 0, INTERVALO, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'd1, 0, INTERVALO, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'd0, 0, INTERVALO, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'd0, 0, RODANDO,   0, 0, 1, 2, 3, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 2, 3, 0));
        // Pause with prescaler at 2, score while paused, resume.
        vecs.push_back(mk(1, 2'd0, 0, PAUSADO,   0, 0, 1, 2, 3, 0));
        vecs.push_back(mk(0, 2'd3, 0, PAUSADO,   3, 0, 1, 2, 3, 0));
        for (int k = 0; k < 8; k++) vecs.push_back(mk(0, 2'd0, 0, PAUSADO, 0, 0, 1, 2, 3, 0));
        vecs.push_back(mk(1, 2'd0, 0, RODANDO,   0, 0, 1, 2, 3, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 2, 3, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 2, 2, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 2'd0, 0, RODANDO, 0, 0, 1, 2, 2, 0));
        vecs.push_back(mk(0, 2'd0, 0, RODANDO,   0, 0, 1, 2, 1, 0));
        for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 2'd0, 0, RODANDO, 0, 0, 1, 2, 1, 0));
        // Last period expires into FIM, points dropped, then back to PARADO.
        vecs.push_back(mk(0, 2'd0, 0, FIM,       0, 0, 1, 2, 0, 1));
        vecs.push_back(mk(0, 2'd1, 0, FIM,       0, 0, 1, 2, 0, 1));
        vecs.push_back(mk(0, 2'd0, 0, FIM,       0, 0, 1, 2, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, PARADO,    0, 0, 1, 1, 3, 0));
        vecs.push_back(mk(0, 2'd0, 0, PARADO,    0, 0, 1, 1, 3, 0));

        rst_v = mk(0, 2'd0, 0, PARADO, 0, 0, 1, 1, 3, 0);

        clr = 1'b0; btn_start = 1'b0; btn_pts = 2'd0; chave_time = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_all(-1, rst_v);
        @(negedge clock);
        clr = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            btn_start  = vecs[i].st;
            btn_pts    = vecs[i].pts;
            chave_time = vecs[i].ch;
            sb.push_back(vecs[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk_all(i, e);
        end

        // Reset in the middle of a running period with a point pulse in flight.
        @(negedge clock);
        btn_start = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_start_estado", 100, int'(estado), int'(RODANDO));
        @(negedge clock);
        btn_start = 1'b0; btn_pts = 2'd1; chave_time = 1'b1;
        @(posedge clock);
        #1;
        chk("mid_pulse_t2", 101, int'(soma_t2), 1);
        #2;
        clr = 1'b0;
        #1;
        chk_all(102, rst_v);
        @(negedge clock);
        clr = 1'b1; btn_pts = 2'd0; chave_time = 1'b0;
        @(posedge clock);
        #1;
        chk_all(103, rst_v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
